// File: rtl/run_supervisor_pkg.sv
// Shared types for the run supervisor: state encoding reported on `status`
// and a helper that classifies the sticky end-of-run states.
package run_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_STALL   = 3'd4
  } run_state_e;

  function automatic logic status_is_terminal(input run_state_e s);
    return (s == ST_PASS) || (s == ST_TIMEOUT) || (s == ST_STALL);
  endfunction

endpackage

// File: rtl/run_supervisor_chan_watchdog.sv
// Per-channel monitor: sticky done bit, saturating idle counter and the
// stall condition for the current cycle.
module chan_watchdog #(
  parameter int STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run_en,
  input  logic [STALL_W-1:0] stall_limit,
  input  logic               progress,
  input  logic               done,
  output logic               done_eff,
  output logic               stall
);

  logic [STALL_W-1:0] idle_q, idle_d;
  logic               mask_q, mask_d;

  always_comb begin
    idle_d = idle_q;
    mask_d = mask_q;
    if (run_en) begin
      mask_d = mask_q | done;
      if (progress)
        idle_d = '0;
      else if (idle_q != '1)
        idle_d = idle_q + STALL_W'(1);
    end
  end

  // A channel that signals done this cycle is already exempt from stalling.
  always_comb begin
    done_eff = mask_q | done;
    stall    = run_en && (stall_limit != '0) && !done_eff && !progress &&
               (idle_q == stall_limit - STALL_W'(1));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      idle_q <= '0;
      mask_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      mask_q <= mask_d;
    end
  end

endmodule

// File: rtl/run_supervisor.sv
// Run controller: sequences DUT reset, counts run cycles against a budget and
// ends the run with a single finish pulse carrying a PASS/TIMEOUT/STALL verdict.
module run_supervisor
  import run_supervisor_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 64,
  parameter int STALL_W      = 16,
  parameter int RESET_CYCLES = 10,
  localparam int FAIL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CNT_W-1:0]   max_cycles,
  input  logic [STALL_W-1:0] stall_limit,
  input  logic [N_CH-1:0]    progress,
  input  logic [N_CH-1:0]    done,
  output logic               dut_reset,
  output logic               running,
  output logic               dump_en,
  output logic               finish,
  output logic [2:0]         status,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [FAIL_W-1:0]  fail_ch
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  run_state_e          state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic                finish_q, finish_d;

  logic [N_CH-1:0]     done_eff;
  logic [N_CH-1:0]     stall_vec;
  logic [FAIL_W-1:0]   stall_idx;
  logic                run_en;
  logic                pass_hit, timeout_hit, stall_hit;

  assign run_en = (state_q == ST_RUN);

  for (genvar g = 0; g < N_CH; g++) begin : g_wd
    chan_watchdog #(.STALL_W(STALL_W)) u_wd (
      .clock       (clock),
      .reset       (reset),
      .run_en      (run_en),
      .stall_limit (stall_limit),
      .progress    (progress[g]),
      .done        (done[g]),
      .done_eff    (done_eff[g]),
      .stall       (stall_vec[g])
    );
  end

  always_comb begin
    pass_hit    = &done_eff;
    timeout_hit = (max_cycles != '0) && (cycle_q == max_cycles - CNT_W'(1));
    stall_hit   = |stall_vec;
    stall_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (stall_vec[i]) stall_idx = FAIL_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_HOLD;
    else        state_q <= state_d;
  end

  // Exit priority is PASS over TIMEOUT over STALL; terminal states are sticky.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HOLD: if (hold_q == HOLD_LAST) state_d = ST_RUN;
      ST_RUN: begin
        if (pass_hit)         state_d = ST_PASS;
        else if (timeout_hit) state_d = ST_TIMEOUT;
        else if (stall_hit)   state_d = ST_STALL;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    dut_reset = (state_q == ST_HOLD);
    running   = (state_q == ST_RUN);
    dump_en   = (state_q == ST_RUN);
    status    = state_q;
  end

  always_comb begin
    hold_d = hold_q;
    if (state_q == ST_HOLD && hold_q != HOLD_LAST) hold_d = hold_q + HOLD_W'(1);
    cycle_d = cycle_q;
    if (run_en && cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
    fail_d = fail_q;
    if (run_en && state_d == ST_STALL) fail_d = stall_idx;
    finish_d = status_is_terminal(state_d) && !status_is_terminal(state_q);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_q   <= '0;
      cycle_q  <= '0;
      fail_q   <= '0;
      finish_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      cycle_q  <= cycle_d;
      fail_q   <= fail_d;
      finish_q <= finish_d;
    end
  end

  assign finish      = finish_q;
  assign cycle_count = cycle_q;
  assign fail_ch     = fail_q;

endmodule

// File: tb/tb_run_supervisor.sv
// Self-checking bench for run_supervisor: a table of whole-run scenarios whose
// verdicts go through a scoreboard queue, plus hand-written reset sequences.
module tb_run_supervisor;

  localparam int RC = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] max_cycles = '0;
  logic [15:0] stall_limit = '0;
  logic [3:0]  progress = '0;
  logic [3:0]  done = '0;
  logic        dut_reset, running, dump_en, finish;
  logic [2:0]  status;
  logic [63:0] cycle_count;
  logic [1:0]  fail_ch;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] max_c;
    logic [15:0] stall_lim;
    int          done_cyc[4];
    int          prog_per[4];
    logic [2:0]  exp_status;
    logic [63:0] exp_count;
    logic [1:0]  exp_fail;
  } vec_t;

  vec_t vecs[10];
  vec_t exp_q[$];

  run_supervisor #(
    .N_CH(4), .CNT_W(64), .STALL_W(16), .RESET_CYCLES(RC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .max_cycles  (max_cycles),
    .stall_limit (stall_limit),
    .progress    (progress),
    .done        (done),
    .dut_reset   (dut_reset),
    .running     (running),
    .dump_en     (dump_en),
    .finish      (finish),
    .status      (status),
    .cycle_count (cycle_count),
    .fail_ch     (fail_ch)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=stuck expected=finished");
    $fatal(1, "[TB] bench did not terminate");
  end

  function automatic vec_t mkv(input logic [63:0] mc, input logic [15:0] sl,
                               input int d0, input int d1, input int d2, input int d3,
                               input int p0, input int p1, input int p2, input int p3,
                               input logic [2:0] es, input logic [63:0] ec,
                               input logic [1:0] ef);
    vec_t v;
    v.max_c = mc;  v.stall_lim = sl;
    v.done_cyc[0] = d0; v.done_cyc[1] = d1; v.done_cyc[2] = d2; v.done_cyc[3] = d3;
    v.prog_per[0] = p0; v.prog_per[1] = p1; v.prog_per[2] = p2; v.prog_per[3] = p3;
    v.exp_status = es; v.exp_count = ec; v.exp_fail = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic holdReset(input string tag);
    @(negedge clock);
    reset = 1'b0; progress = '0; done = '0;
    repeat (3) @(negedge clock);
    chk({tag, "_rst_status"}, 64'(status), 64'd0);
    chk({tag, "_rst_dut_reset"}, 64'(dut_reset), 64'd1);
    chk({tag, "_rst_finish"}, 64'(finish), 64'd0);
  endtask

  // Called at a negedge after reset was sampled low; returns at RUN cycle 1.
  task automatic releaseReset(input string tag);
    int cnt;
    cnt = 0;
    reset = 1'b1;
    while (cnt < 40 && dut_reset === 1'b1 && running !== 1'b1) begin
      cnt++;
      @(negedge clock);
    end
    chk({tag, "_hold_len"}, 64'(cnt), 64'(RC));
    chk({tag, "_running"}, 64'(running), 64'd1);
    chk({tag, "_run_status"}, 64'(status), 64'd1);
    chk({tag, "_run_dump_en"}, 64'(dump_en), 64'd1);
    chk({tag, "_run_count0"}, cycle_count, 64'd0);
  endtask

  task automatic checkOutput(input vec_t e, input string tag);
    chk({tag, "_finish"}, 64'(finish), 64'd1);
    chk({tag, "_status"}, 64'(status), 64'(e.exp_status));
    chk({tag, "_cycle_count"}, cycle_count, e.exp_count);
    chk({tag, "_fail_ch"}, 64'(fail_ch), 64'(e.exp_fail));
    chk({tag, "_dump_en"}, 64'(dump_en), 64'd0);
    chk({tag, "_dut_reset"}, 64'(dut_reset), 64'd0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    int    k;
    bit    seen;
    vec_t  e;
    tag = $sformatf("v%0d", idx);
    holdReset(tag);
    max_cycles  = v.max_c;
    stall_limit = v.stall_lim;
    exp_q.push_back(v);
    releaseReset(tag);
    k = 1;
    seen = 1'b0;
    while (!seen && k <= 400) begin
      for (int i = 0; i < 4; i++) begin
        done[i]     = (v.done_cyc[i] == k);
        progress[i] = (v.prog_per[i] != 0) && ((k % v.prog_per[i]) == 0);
      end
      @(negedge clock);
      if (finish === 1'b1) seen = 1'b1;
      else k++;
    end
    progress = '0;
    done = '0;
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_no_finish actual=none expected=pulse", tag);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_scoreboard actual=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      checkOutput(e, tag);
      // Terminal state must hold and ignore inputs; finish must not repeat.
      for (int j = 0; j < 3; j++) begin
        done = '1;
        progress = 4'($urandom);
        @(negedge clock);
        chk($sformatf("%s_post%0d_finish", tag, j), 64'(finish), 64'd0);
        chk($sformatf("%s_post%0d_status", tag, j), 64'(status), 64'(e.exp_status));
        chk($sformatf("%s_post%0d_count", tag, j), cycle_count, e.exp_count);
      end
      done = '0;
      progress = '0;
    end
  endtask

  task automatic midRunReset();
    int fin_cnt;
    fin_cnt = 0;
    holdReset("mr");
    max_cycles = '0;
    stall_limit = '0;
    releaseReset("mr");
    for (int k = 1; k < 20; k++) begin
      @(negedge clock);
      if (finish === 1'b1) fin_cnt++;
    end
    chk("mr_count_at_20", cycle_count, 64'd19);
    chk("mr_running_at_20", 64'(running), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("mr_status_hold", 64'(status), 64'd0);
    chk("mr_dut_reset", 64'(dut_reset), 64'd1);
    chk("mr_count_clear", cycle_count, 64'd0);
    chk("mr_running_low", 64'(running), 64'd0);
    if (finish === 1'b1) fin_cnt++;
    releaseReset("mr2");
    for (int k = 1; k < 5; k++) begin
      @(negedge clock);
      if (finish === 1'b1) fin_cnt++;
    end
    chk("mr_restart_count", cycle_count, 64'd4);
    chk("mr_finish_pulses", 64'(fin_cnt), 64'd0);
  endtask

  initial begin
    //            max   stall  done cycles    progress period  status count fail
    vecs[0] = mkv(100,  0,   0, 0, 0, 0,     0, 0, 0, 0,     3'd3, 100, 2'd0);
    vecs[1] = mkv(0,    0,   5, 20, 30, 40,  0, 0, 0, 0,     3'd2, 40,  2'd0);
    vecs[2] = mkv(0,    8,   0, 0, 0, 0,     3, 3, 0, 3,     3'd4, 8,   2'd2);
    vecs[3] = mkv(50,   0,   10, 10, 10, 50, 0, 0, 0, 0,     3'd2, 50,  2'd0);
    vecs[4] = mkv(0,    5,   0, 0, 0, 0,     2, 0, 2, 0,     3'd4, 5,   2'd1);
    vecs[5] = mkv(30,   4,   2, 0, 0, 0,     0, 1, 1, 1,     3'd3, 30,  2'd0);
    vecs[6] = mkv(6,    6,   0, 0, 0, 0,     0, 0, 0, 0,     3'd3, 6,   2'd0);
    vecs[7] = mkv(1,    0,   0, 0, 0, 0,     0, 0, 0, 0,     3'd3, 1,   2'd0);
    vecs[8] = mkv(0,    1,   0, 0, 0, 0,     1, 1, 1, 0,     3'd4, 1,   2'd3);
    vecs[9] = mkv(0,    3,   1, 1, 1, 3,     0, 0, 0, 0,     3'd2, 3,   2'd0);

    $display("[TB] start");
    repeat (2) @(negedge clock);
    chk("init_running", 64'(running), 64'd0);
    chk("init_dump_en", 64'(dump_en), 64'd0);
    chk("init_count", cycle_count, 64'd0);
    chk("init_fail_ch", 64'(fail_ch), 64'd0);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);
    midRunReset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_supervisor.md
# run_supervisor

Synthesizable simulation run-controller: the parametrised successor to hand-written bench clock/reset/timeout logic. Sits between the top-level bench shell and the DUT. Sequences DUT reset for a programmable number of cycles and counts run cycles against a cycle budget. Watches N independent progress/done channels and ends the run with a single one-cycle `finish` pulse carrying a PASS/TIMEOUT/STALL verdict that the shell turns into dump-off and `$finish`.

## Interface
Parameters:
- `N_CH`, 4: number of monitored DUT channels (≥1)
- `CNT_W`, 64: width of cycle counter and `max_cycles`
- `STALL_W`, 16: width of per-channel idle counters and `stall_limit`
- `RESET_CYCLES`, 10: DUT reset hold length in cycles (≥1)

Ports:
- `clock`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low; block reset while sampled 0
- `max_cycles`  in  CNT_W  run budget; 0 = unlimited; quasi-static after reset release
- `stall_limit`  in  STALL_W  per-channel idle limit; 0 = watchdog disabled; quasi-static
- `progress`  in  N_CH  per-channel one-cycle activity strobes
- `done`  in  N_CH  per-channel completion strobes (level or pulse)
- `dut_reset`  out  1  active-high reset to DUT
- `running`  out  1  high while in RUN
- `dump_en`  out  1  waveform dump enable; equals `running`
- `finish`  out  1  one-cycle pulse on entry to a terminal state
- `status`  out  3  current state code (package enum)
- `cycle_count`  out  CNT_W  completed RUN cycles
- `fail_ch`  out  $clog2(N_CH) (min 1)  lowest stalled channel index; 0 unless STALL

## Operation
- States: HOLD(0), RUN(1), PASS(2), TIMEOUT(3), STALL(4). PASS/TIMEOUT/STALL are terminal and sticky until `reset` = 0.
- Reset (`reset` = 0 at an edge): state HOLD, hold counter 0, `cycle_count` 0, done mask 0, idle counters 0; outputs `dut_reset`=1, `running`=0, `dump_en`=0, `finish`=0, `status`=0, `fail_ch`=0.
- HOLD: `dut_reset`=1; hold counter increments each non-reset cycle; at the edge where it equals RESET_CYCLES−1 go to RUN.
- RUN: `dut_reset`=0, `cycle_count` += 1 per cycle.
- Done mask: `done[i]` sets sticky bit i. A done channel is excluded from stall checking.
- Per-channel idle counter: cleared on `progress[i]`, else increments, saturating at all-ones.
- Exit conditions evaluated each RUN cycle, with current-cycle inputs included:
  - pass = (mask | `done`) all ones
  - timeout = `max_cycles`≠0 and `cycle_count` == `max_cycles`−1
  - stall = `stall_limit`≠0 and some not-done channel i has no `progress[i]` this cycle and idle_cnt[i] == `stall_limit`−1
- Priority on simultaneous conditions: PASS > TIMEOUT > STALL. `fail_ch` is the lowest stalled index, latched on STALL entry.
- Terminal states: `cycle_count` frozen, inputs ignored.
- `finish` is high only on the first terminal cycle.
- `reset` = 0 mid-RUN or in a terminal state restarts from HOLD next cycle; no `finish` is emitted.

## Timing
- `reset` released at edge E0: `dut_reset` high for exactly RESET_CYCLES cycles; `running` rises at edge E0+RESET_CYCLES.
- Without other exits, RUN lasts exactly `max_cycles` cycles. Entry to TIMEOUT with `cycle_count` == `max_cycles`.
- All status outputs are registered; inputs to state change take one cycle.
- Stall fires after `stall_limit` consecutive progress-free RUN cycles on a channel.
- `cycle_count` saturates at all-ones when unlimited.

## Structure
- `run_supervisor_pkg`: `run_state_e` enum (3-bit, codes above) and a `status_is_terminal()` function.
- One sub-module `chan_watchdog` (per channel, generate loop): idle counter, done-mask bit, stall flag. Parent holds FSM, hold counter, cycle counter, priority encoder.

## Test plan
- RESET_CYCLES=10, release `reset` → `dut_reset` high exactly 10 cycles, `running` rises on cycle 11, `status`=1.
- `max_cycles`=100, no done, `stall_limit`=0 → `finish` pulse after 100 RUN cycles; `status`=3, `cycle_count`=100, `dump_en`=0.
- N_CH=4, `done` pulses on ch 0,1,2 at cycles 5/20/30, ch3 at cycle 40 → PASS entered cycle 41, `finish` single pulse.
- `stall_limit`=8, ch2 silent, others pulse every 3 cycles → STALL after 8 idle cycles; `fail_ch`=2.
- All done and timeout in the same cycle (`max_cycles`=50, final done at RUN cycle 50) → `status`=2, not 3.
- `reset`=0 at RUN cycle 20 → next cycle HOLD, `cycle_count`=0, `finish` never pulses, and the sequence restarts.
